pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage core, the generalised successor of the fixed EX/MEM latch. It captures a packed payload from an upstream stage, honours the central stall vector (hold, bubble insertion), adds a synchronous flush for exception/branch squash, and carries a multi-cycle scratch state (HI/LO accumulator plus step count) back to the upstream stage while that stage is stalled. One instance per stage boundary, selected by `STAGE`.

## Interface
Parameters:
- `DATA_W`, 72: payload width (wdata, wd, wreg, whilo, hi, lo, … packed by the instantiating stage).
- `SCR_W`, 64: multi-cycle scratch width (HI:LO accumulator).
- `CNT_W`, 2: multi-cycle step-count width.
- `STALL_W`, 6: stall vector width.
- `STAGE`, 3: stall bit index of the upstream stage; legal range 0..`STALL_W`-2.

Ports:
- Reset `rst` is synchronous and active-high; clock is `clk`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous active-high reset.
- `stall` in `STALL_W`: central stall vector, bit i = 1 stops stage i.
- `flush` in 1: squash this stage's contents.
- `in_valid` in 1: upstream payload valid.
- `in_data` in `DATA_W`: upstream payload.
- `scr_i` in `SCR_W`: scratch state from the upstream stage.
- `cnt_i` in `CNT_W`: step count from the upstream stage.
- `out_valid` out 1: registered payload valid.
- `out_data` out `DATA_W`: registered payload.
- `scr_o` out `SCR_W`: scratch state returned to the upstream stage.
- `cnt_o` out `CNT_W`: step count returned to the upstream stage.
- `bubble_cnt` out 32: bubbles inserted (see Configuration).
- `hold_cnt` out 32: cycles held (see Configuration).

## Operation
Let `up = stall[STAGE]` and `dn = stall[STAGE+1]`. Each cycle exactly one action applies, in this priority order:
1. **RESET** (`rst`=1): `out_valid`=0, `out_data`=0, `scr_o`=0, `cnt_o`=0. The counters also clear to 0.
2. **FLUSH** (`flush`=1): `out_valid`=0, `out_data`=0, `scr_o`=0, `cnt_o`=0. Any in-progress multi-cycle operation is abandoned. Flush overrides all stall combinations.
3. **BUBBLE** (`up`=1, `dn`=0): `out_valid`=0 and `out_data`=0, so no register or HI/LO write can leak downstream. `scr_o`<=`scr_i` and `cnt_o`<=`cnt_i`.
4. **ADVANCE** (`up`=0):
   - `out_valid`<=`in_valid`.
   - `out_data`<=`in_valid` ? `in_data` : 0.
   - `scr_o`<=0, `cnt_o`<=0.
5. **HOLD** (`up`=1, `dn`=1): `out_valid` and `out_data` keep their values. `scr_o`<=`scr_i` and `cnt_o`<=`cnt_i`.

Further rules:
- Invalid payloads are always stored as zero. Downstream logic may rely on `out_data`=0 whenever `out_valid`=0.
- The scratch path is a pure register with no arithmetic. `cnt` is not incremented here; the upstream stage owns it.

## Timing
- Latency: 1 cycle from `in_*` to `out_*` on ADVANCE.
- Feedback latency: 1 cycle from `scr_i`/`cnt_i` to `scr_o`/`cnt_o` on BUBBLE or HOLD.
- No combinational paths from any input to any output.
- A stall that releases (`up` 1→0) loads the new `in_data` on that edge and zeroes the scratch in the same cycle.
- When `flush` and `rst` are asserted together, the result is the reset result, including the counters.
- When `flush` is asserted during HOLD, the outputs clear on that edge.
- `dn`=0 together with `up`=1 is the only state that creates a bubble. `up`=0 with `dn`=1 is an illegal vector from the stall controller; it is treated as ADVANCE and must not be flagged.

## Configuration
- Macro: `PIPE_PERF_CNT_EN`.
- Defined: two 32-bit saturating counters, each reset to 0 only by `rst` (`flush` does not clear them). Each saturates at 0xFFFFFFFF.
  - `bubble_cnt` increments on every BUBBLE cycle.
  - `hold_cnt` increments on every HOLD cycle.
- Undefined: the counter logic is removed, and `bubble_cnt`/`hold_cnt` are constant 0. The ports remain, so instantiation is identical in both builds.

## Test plan
1. **Reset:** `rst`=1 for 2 cycles with `in_data`=0xAA… and `in_valid`=1 → all outputs 0. After release with `stall`=0, `out_data`=0xAA… one cycle later.
2. **Bubble:** `stall`=6'b001111 with `STAGE`=3, `scr_i`=0x1234_5678_9ABC_DEF0, `cnt_i`=2'b01 → `out_valid`=0, `out_data`=0, `scr_o`=0x1234_5678_9ABC_DEF0, `cnt_o`=1. With `PIPE_PERF_CNT_EN`, `bubble_cnt`=1 per bubble cycle.
3. **Hold:** load `out_data`=0x55 by advancing, then `stall`=6'b011111 for 3 cycles → `out_data` stays 0x55, `scr_o` tracks `scr_i` each cycle, and `hold_cnt`=3.
4. **Release:** stall drops to 0 with `in_data`=0x77 and `in_valid`=1 → next edge `out_data`=0x77, `scr_o`=0, `cnt_o`=0.
5. **Flush priority:** `flush`=1 together with `stall`=6'b011111 while `out_data`=0x55 → next edge `out_valid`=0, `out_data`=0, `cnt_o`=0. The counters are unchanged by the flush.
6. **Invalid zeroing and saturation:**
   - `in_valid`=0 with `in_data`=0xFF on ADVANCE → `out_data`=0.
   - Force `bubble_cnt` to 0xFFFFFFFE, then apply 3 bubble cycles → `bubble_cnt` reads 0xFFFFFFFF.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Bundle of the stage-boundary signals carried by one
//               pipe_stage_reg instance: stall vector, flush, upstream
//               payload and scratch inputs, and the registered payload,
//               scratch feedback and performance counters.
//               Modport "slave" is the register itself; modport "master"
//               is the side that drives it (upstream stage / controller).
// Ports       : stall[STALL_W]  central stall vector, bit i stops stage i
//               flush           squash this stage's contents
//               in_valid/in_data       upstream payload
//               scr_i/cnt_i            scratch state from upstream
//               out_valid/out_data     registered payload
//               scr_o/cnt_o            scratch state returned upstream
//               bubble_cnt/hold_cnt    32-bit performance counters
// Revision    : 1.0  initial release
// ============================================================================
interface pipe_stage_reg_if #(
   parameter int DATA_W  = 72,
   parameter int SCR_W   = 64,
   parameter int CNT_W   = 2,
   parameter int STALL_W = 6
);
   logic [STALL_W-1:0] stall;
   logic               flush;
   logic               in_valid;
   logic [DATA_W-1:0]  in_data;
   logic [SCR_W-1:0]   scr_i;
   logic [CNT_W-1:0]   cnt_i;
   logic               out_valid;
   logic [DATA_W-1:0]  out_data;
   logic [SCR_W-1:0]   scr_o;
   logic [CNT_W-1:0]   cnt_o;
   logic [31:0]        bubble_cnt;
   logic [31:0]        hold_cnt;

   modport master (
      output stall, flush, in_valid, in_data, scr_i, cnt_i,
      input  out_valid, out_data, scr_o, cnt_o, bubble_cnt, hold_cnt
   );

   modport slave (
      input  stall, flush, in_valid, in_data, scr_i, cnt_i,
      output out_valid, out_data, scr_o, cnt_o, bubble_cnt, hold_cnt
   );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised inter-stage pipeline register. Captures the
//               upstream payload, honours the central stall vector (hold and
//               bubble insertion), supports a synchronous flush, and returns
//               a multi-cycle scratch state (HI:LO accumulator + step count)
//               to the upstream stage while that stage is stalled.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - pipe_stage_reg_if.slave (stall, flush, in_*, scr_i,
//                      cnt_i, out_*, scr_o, cnt_o, bubble_cnt, hold_cnt)
// Config      : PIPE_PERF_CNT_EN - when defined, bubble_cnt/hold_cnt are
//               32-bit saturating counters cleared only by rst; otherwise
//               both read constant 0.
// Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
   parameter int DATA_W  = 72,
   parameter int SCR_W   = 64,
   parameter int CNT_W   = 2,
   parameter int STALL_W = 6,
   parameter int STAGE   = 3     // stall bit of the upstream stage, 0..STALL_W-2
) (
   input  wire logic       clk,
   input  wire logic       rst,
   pipe_stage_reg_if.slave bus
);

   localparam int C_UP_IDX = STAGE;
   localparam int C_DN_IDX = STAGE + 1;

   // One action per cycle, resolved in priority order.
   typedef enum logic [2:0] {
      ACT_RESET   = 3'd0,
      ACT_FLUSH   = 3'd1,
      ACT_BUBBLE  = 3'd2,
      ACT_ADVANCE = 3'd3,
      ACT_HOLD    = 3'd4
   } action_t;

   action_t           w_action;
   logic              w_up;
   logic              w_dn;

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [SCR_W-1:0]  r_scr;
   logic [CNT_W-1:0]  r_cnt;

   assign w_up = bus.stall[C_UP_IDX];
   assign w_dn = bus.stall[C_DN_IDX];

   // up=0 with dn=1 is not a legal controller output; it falls into ADVANCE
   // silently because only up decides whether new data is accepted.
   always_comb begin
      w_action = ACT_ADVANCE;
      if (rst) begin
         w_action = ACT_RESET;
      end else if (bus.flush) begin
         w_action = ACT_FLUSH;
      end else if (w_up && !w_dn) begin
         w_action = ACT_BUBBLE;
      end else if (w_up && w_dn) begin
         w_action = ACT_HOLD;
      end
   end

   // Payload register. Invalid payloads are always stored as zero so that
   // downstream write enables inside the payload can never leak.
   always_ff @(posedge clk) begin
      unique case (w_action)
         ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
            r_valid <= 1'b0;
            r_data  <= '0;
         end
         ACT_ADVANCE: begin
            r_valid <= bus.in_valid;
            r_data  <= bus.in_valid ? bus.in_data : '0;
         end
         ACT_HOLD: begin
            r_valid <= r_valid;
            r_data  <= r_data;
         end
         default: begin
            r_valid <= 1'b0;
            r_data  <= '0;
         end
      endcase
   end

   // Scratch feedback: a plain register that only carries the upstream
   // multi-cycle state while that stage is stalled; any advance or squash
   // discards it.
   always_ff @(posedge clk) begin
      unique case (w_action)
         ACT_BUBBLE, ACT_HOLD: begin
            r_scr <= bus.scr_i;
            r_cnt <= bus.cnt_i;
         end
         default: begin
            r_scr <= '0;
            r_cnt <= '0;
         end
      endcase
   end

   assign bus.out_valid = r_valid;
   assign bus.out_data  = r_data;
   assign bus.scr_o     = r_scr;
   assign bus.cnt_o     = r_cnt;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] r_bubble_cnt;
   logic [31:0] r_hold_cnt;

   // Flush is a separate action, so a flushed cycle is neither a bubble
   // nor a hold and leaves both counters untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bubble_cnt <= '0;
         r_hold_cnt   <= '0;
      end else begin
         if (w_action == ACT_BUBBLE && r_bubble_cnt != 32'hFFFF_FFFF) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
         end
         if (w_action == ACT_HOLD && r_hold_cnt != 32'hFFFF_FFFF) begin
            r_hold_cnt <= r_hold_cnt + 32'd1;
         end
      end
   end

   assign bus.bubble_cnt = r_bubble_cnt;
   assign bus.hold_cnt   = r_hold_cnt;
`else
   assign bus.bubble_cnt = 32'd0;
   assign bus.hold_cnt   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg (STAGE=3, default
//               widths). A behavioural model tracks the expected outputs
//               from the action rules and is compared on every falling edge;
//               directed steps add hand-computed literal expectations.
//               Counter expectations follow PIPE_PERF_CNT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

   localparam int DATA_W  = 72;
   localparam int SCR_W   = 64;
   localparam int CNT_W   = 2;
   localparam int STALL_W = 6;
   localparam int STAGE   = 3;
`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [5:0]  S_NONE   = 6'b000000;
   localparam logic [5:0]  S_BUBBLE = 6'b001111;
   localparam logic [5:0]  S_HOLD   = 6'b011111;
   localparam logic [5:0]  S_ILLEG  = 6'b010000;
   localparam logic [63:0] SCR1     = 64'h1234_5678_9ABC_DEF0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   pipe_stage_reg_if #(.DATA_W(DATA_W), .SCR_W(SCR_W), .CNT_W(CNT_W), .STALL_W(STALL_W)) bus ();

   pipe_stage_reg #(
      .DATA_W(DATA_W), .SCR_W(SCR_W), .CNT_W(CNT_W), .STALL_W(STALL_W), .STAGE(STAGE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit              model_ok = 1'b0;
   logic            m_valid;
   logic [71:0]     m_data;
   logic [63:0]     m_scr;
   logic [1:0]      m_cnt;
   logic [31:0]     m_bub  = '0;
   logic [31:0]     m_hold = '0;

   always @(posedge clk) begin
      logic up, dn;
      up = bus.stall[STAGE];
      dn = bus.stall[STAGE+1];
      if (rst) begin
         m_valid = 1'b0; m_data = '0; m_scr = '0; m_cnt = '0;
         m_bub = '0; m_hold = '0;
         model_ok = 1'b1;
      end else if (bus.flush) begin
         m_valid = 1'b0; m_data = '0; m_scr = '0; m_cnt = '0;
      end else if (up && !dn) begin
         m_valid = 1'b0; m_data = '0; m_scr = bus.scr_i; m_cnt = bus.cnt_i;
         if (PERF && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
      end else if (!up) begin
         m_valid = bus.in_valid;
         m_data  = bus.in_valid ? bus.in_data : 72'd0;
         m_scr = '0; m_cnt = '0;
      end else begin
         m_scr = bus.scr_i; m_cnt = bus.cnt_i;
         if (PERF && m_hold != 32'hFFFF_FFFF) m_hold = m_hold + 1;
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT against the model every cycle once reset has been seen.
   always @(negedge clk) begin
      if (model_ok) begin
         chk("m_out_valid",  {127'd0, bus.out_valid}, {127'd0, m_valid});
         chk("m_out_data",   {56'd0, bus.out_data},   {56'd0, m_data});
         chk("m_scr_o",      {64'd0, bus.scr_o},      {64'd0, m_scr});
         chk("m_cnt_o",      {126'd0, bus.cnt_o},     {126'd0, m_cnt});
         chk("m_bubble_cnt", {96'd0, bus.bubble_cnt}, {96'd0, m_bub});
         chk("m_hold_cnt",   {96'd0, bus.hold_cnt},   {96'd0, m_hold});
      end
   end

   // Drive one cycle of inputs, then return 1 time unit after the edge.
   task automatic apply(input logic r, input logic [5:0] st, input logic fl,
                        input logic v, input logic [71:0] d,
                        input logic [63:0] s, input logic [1:0] c);
      rst          = r;
      bus.stall    = st;
      bus.flush    = fl;
      bus.in_valid = v;
      bus.in_data  = d;
      bus.scr_i    = s;
      bus.cnt_i    = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [71:0] aa;
      aa = {9{8'hAA}};

      // Reset with a valid payload present
      apply(1'b1, S_NONE, 1'b0, 1'b1, aa, SCR1, 2'd3);
      apply(1'b1, S_NONE, 1'b0, 1'b1, aa, SCR1, 2'd3);
      chk("rst_valid", {127'd0, bus.out_valid}, 128'd0);
      chk("rst_data",  {56'd0, bus.out_data},   128'd0);
      chk("rst_scr",   {64'd0, bus.scr_o},      128'd0);
      chk("rst_cnt",   {126'd0, bus.cnt_o},     128'd0);

      apply(1'b0, S_NONE, 1'b0, 1'b1, aa, SCR1, 2'd3);
      chk("adv_data_aa", {56'd0, bus.out_data}, {56'd0, aa});
      chk("adv_valid",   {127'd0, bus.out_valid}, 128'd1);

      // Bubble
      apply(1'b0, S_BUBBLE, 1'b0, 1'b1, 72'hDEAD, SCR1, 2'b01);
      chk("bub_valid", {127'd0, bus.out_valid}, 128'd0);
      chk("bub_data",  {56'd0, bus.out_data},   128'd0);
      chk("bub_scr",   {64'd0, bus.scr_o},      {64'd0, SCR1});
      chk("bub_cnt",   {126'd0, bus.cnt_o},     128'd1);
      chk("bub_count", {96'd0, bus.bubble_cnt}, PERF ? 128'd1 : 128'd0);

      // Hold for three cycles after loading 0x55
      apply(1'b0, S_NONE, 1'b0, 1'b1, 72'h55, SCR1, 2'd2);
      chk("load_55", {56'd0, bus.out_data}, 128'h55);
      chk("load_scr0", {64'd0, bus.scr_o}, 128'd0);
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, S_HOLD, 1'b0, 1'b1, 72'h66, SCR1 + 64'(i), 2'(i));
         chk("hold_data", {56'd0, bus.out_data}, 128'h55);
         chk("hold_scr",  {64'd0, bus.scr_o},    {64'd0, SCR1 + 64'(i)});
      end
      chk("hold_count", {96'd0, bus.hold_cnt}, PERF ? 128'd3 : 128'd0);

      // Release
      apply(1'b0, S_NONE, 1'b0, 1'b1, 72'h77, SCR1, 2'd3);
      chk("rel_data", {56'd0, bus.out_data}, 128'h77);
      chk("rel_scr",  {64'd0, bus.scr_o},    128'd0);
      chk("rel_cnt",  {126'd0, bus.cnt_o},   128'd0);

      // Flush over hold
      apply(1'b0, S_NONE, 1'b0, 1'b1, 72'h55, SCR1, 2'd0);
      apply(1'b0, S_HOLD, 1'b1, 1'b1, 72'h88, SCR1, 2'd2);
      chk("fl_valid", {127'd0, bus.out_valid}, 128'd0);
      chk("fl_data",  {56'd0, bus.out_data},   128'd0);
      chk("fl_cnt",   {126'd0, bus.cnt_o},     128'd0);
      chk("fl_hold_kept", {96'd0, bus.hold_cnt},   PERF ? 128'd3 : 128'd0);
      chk("fl_bub_kept",  {96'd0, bus.bubble_cnt}, PERF ? 128'd1 : 128'd0);

      // Illegal vector up=0, dn=1 behaves as advance
      apply(1'b0, S_ILLEG, 1'b0, 1'b1, 72'h99, SCR1, 2'd1);
      chk("illeg_data", {56'd0, bus.out_data}, 128'h99);
      chk("illeg_scr",  {64'd0, bus.scr_o},    128'd0);

      // Invalid payload is stored as zero
      apply(1'b0, S_NONE, 1'b0, 1'b0, 72'hFF, SCR1, 2'd1);
      chk("inv_data",  {56'd0, bus.out_data},   128'd0);
      chk("inv_valid", {127'd0, bus.out_valid}, 128'd0);

      // Flush during a bubble request is not a bubble
      apply(1'b0, S_BUBBLE, 1'b1, 1'b1, 72'h11, SCR1, 2'd1);
      chk("flb_scr",   {64'd0, bus.scr_o},      128'd0);
      chk("flb_count", {96'd0, bus.bubble_cnt}, PERF ? 128'd1 : 128'd0);

      // Saturation
`ifdef PIPE_PERF_CNT_EN
      force dut.r_bubble_cnt = 32'hFFFF_FFFE;
      m_bub = 32'hFFFF_FFFE;
      #1;
      release dut.r_bubble_cnt;
`endif
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, S_BUBBLE, 1'b0, 1'b1, 72'h22, SCR1, 2'd0);
      end
      chk("sat_bubble", {96'd0, bus.bubble_cnt}, PERF ? 128'hFFFF_FFFF : 128'd0);

      // Reset together with flush clears the counters as well
      apply(1'b1, S_HOLD, 1'b1, 1'b1, 72'h33, SCR1, 2'd2);
      chk("rstfl_bub",  {96'd0, bus.bubble_cnt}, 128'd0);
      chk("rstfl_hold", {96'd0, bus.hold_cnt},   128'd0);
      chk("rstfl_data", {56'd0, bus.out_data},   128'd0);

      apply(1'b0, S_NONE, 1'b0, 1'b0, 72'd0, 64'd0, 2'd0);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
